// File: rtl/core_dbg_pkg.sv
// Shared definitions for the core run monitor: halt causes, run FSM states, trace entry layout.
// Latency: n/a (constants and a width helper only).
// Backpressure: n/a.
package core_dbg_pkg;

   // Halt cause codes reported on halt_cause
   localparam logic [1:0] CAUSE_NONE    = 2'd0;
   localparam logic [1:0] CAUSE_ECALL   = 2'd1;
   localparam logic [1:0] CAUSE_EBREAK  = 2'd2;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

   // Run-control FSM encoding
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } run_state_e;

   // Trace entry is {pc, rd, data}; rd is a RISC-V register index
   localparam int REG_IDX_W = 5;

   // Total packed width of one trace entry for a given datapath width
   function automatic int trace_entry_w(input int xlen);
      return 2 * xlen + REG_IDX_W;
   endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO with sync flush and a sticky overflow flag for dropped pushes.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: none; a push into a full FIFO without a pop is dropped and flagged.
module trace_fifo #(
   parameter int WIDTH = 69,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_dat,
   input  logic                       pop,
   output logic [WIDTH-1:0]           head_dat,
   output logic                       head_vld,
   output logic [$clog2(DEPTH)+1-1:0] level,
   output logic                       overflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = $clog2(DEPTH) + 1;

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             overflow_q, overflow_d;
   logic [WIDTH-1:0] mem_q [DEPTH];

   logic full;
   logic empty;
   logic pop_ok;
   logic push_ok;
   logic mem_we;

   // Occupancy flags; a pop on a full FIFO frees the slot the simultaneous push needs
   always_comb begin
      full    = (level_q == LVL_W'(DEPTH));
      empty   = (level_q == '0);
      pop_ok  = pop && !empty;
      push_ok = push && (!full || pop_ok);
      mem_we  = push_ok && !flush;
   end

   // Next-state for pointers, level and sticky overflow; flush wins over everything
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      overflow_d = overflow_q;
      if (flush) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         level_d    = '0;
         overflow_d = 1'b0;
      end else begin
         // Power-of-two depth lets the pointers wrap by natural overflow
         if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         level_d    = level_q + LVL_W'(push_ok) - LVL_W'(pop_ok);
         overflow_d = overflow_q | (push && !push_ok);
      end
   end

   // Pointer, level and overflow registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         overflow_q <= overflow_d;
      end
   end

   // Entry storage; cleared on reset so the head reads zero after reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (mem_we) begin
         mem_q[wr_ptr_q] <= push_dat;
      end
   end

   // Head is read straight from storage
   always_comb begin
      head_dat = mem_q[rd_ptr_q];
      head_vld = !empty;
      level    = level_q;
      overflow = overflow_q;
   end

endmodule

// File: rtl/core_run_monitor.sv
// Run-control FSM, cycle/retire counters, halt-cause capture and writeback trace for the core.
// Latency: status registered one cycle after the causing edge; trace head visible the cycle after push.
// Backpressure: none; trace entries are dropped (sticky trace_overflow) when the FIFO is full.
module core_run_monitor
   import core_dbg_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int CYCLE_W     = 64,
   parameter int TRACE_DEPTH = 16,
   parameter int TRACE_X0    = 0
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             start,
   input  logic                             clear,
   input  logic [CYCLE_W-1:0]               timeout_cycles,
   input  logic                             filter_en,
   input  logic [4:0]                       filter_rd,
   input  logic                             wb_wen,
   input  logic [4:0]                       wb_rd,
   input  logic [XLEN-1:0]                  wb_data,
   input  logic [XLEN-1:0]                  wb_pc,
   input  logic                             ecall_pulse,
   input  logic                             ebreak_pulse,
   input  logic [XLEN-1:0]                  halt_pc,
   output logic                             running,
   output logic                             halted,
   output logic [1:0]                       halt_cause,
   output logic [XLEN-1:0]                  halt_pc_q,
   output logic [CYCLE_W-1:0]               cycle_count,
   output logic [CYCLE_W-1:0]               retire_count,
   output logic                             trace_valid,
   output logic [XLEN-1:0]                  trace_pc,
   output logic [4:0]                       trace_rd,
   output logic [XLEN-1:0]                  trace_data,
   input  logic                             trace_pop,
   output logic [$clog2(TRACE_DEPTH)+1-1:0] trace_level,
   output logic                             trace_overflow
);

   localparam int ENTRY_W = trace_entry_w(XLEN);

   run_state_e         state_q, state_d;
   logic               running_q, halted_q;
   logic [CYCLE_W-1:0] cycle_count_q, cycle_count_d;
   logic [CYCLE_W-1:0] retire_count_q, retire_count_d;
   logic [1:0]         halt_cause_q, halt_cause_d;
   logic [XLEN-1:0]    halt_pc_d;

   logic               in_run;
   logic               timeout_hit;
   logic [1:0]         cause_evt;
   logic               halt_evt;
   logic               wb_counted;
   logic               trace_push;
   logic [ENTRY_W-1:0] push_entry;
   logic [ENTRY_W-1:0] head_entry;

   // Halt detection: ecall beats ebreak beats timeout; a restart suppresses the halt
   always_comb begin
      in_run      = (state_q == ST_RUN);
      timeout_hit = (timeout_cycles != '0) &&
                    (cycle_count_q == (timeout_cycles - CYCLE_W'(1)));
      cause_evt   = CAUSE_NONE;
      if (ecall_pulse)       cause_evt = CAUSE_ECALL;
      else if (ebreak_pulse) cause_evt = CAUSE_EBREAK;
      else if (timeout_hit)  cause_evt = CAUSE_TIMEOUT;
      halt_evt    = in_run && !start && (cause_evt != CAUSE_NONE);
   end

   // Writeback qualification: retire counts every non-x0 write, trace applies the x0 and rd filters
   always_comb begin
      wb_counted = wb_wen && (wb_rd != 5'd0);
      trace_push = in_run && !start && wb_wen &&
                   ((wb_rd != 5'd0) || (TRACE_X0 != 0)) &&
                   (!filter_en || (wb_rd == filter_rd));
      push_entry = {wb_pc, wb_rd, wb_data};
   end

   // Next FSM state; start takes priority over clear and over a same-cycle halt
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (start) state_d = ST_RUN;
         ST_RUN:    if (start) state_d = ST_RUN;
                    else if (halt_evt) state_d = ST_HALTED;
         ST_HALTED: if (start) state_d = ST_RUN;
                    else if (clear) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Run-control FSM with registered running/halted status
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         running_q <= 1'b0;
         halted_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         running_q <= (state_d == ST_RUN);
         halted_q  <= (state_d == ST_HALTED);
      end
   end

   // Counter and halt-capture next-state; counters freeze outside RUN and wrap silently
   always_comb begin
      cycle_count_d  = cycle_count_q;
      retire_count_d = retire_count_q;
      halt_cause_d   = halt_cause_q;
      halt_pc_d      = halt_pc_q;
      if (start) begin
         cycle_count_d  = '0;
         retire_count_d = '0;
         halt_cause_d   = CAUSE_NONE;
      end else if (in_run) begin
         cycle_count_d  = cycle_count_q + CYCLE_W'(1);
         retire_count_d = retire_count_q + CYCLE_W'(wb_counted);
         if (halt_evt) begin
            halt_cause_d = cause_evt;
            halt_pc_d    = halt_pc;
         end
      end
   end

   // Counter and halt-capture registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_count_q  <= '0;
         retire_count_q <= '0;
         halt_cause_q   <= CAUSE_NONE;
         halt_pc_q      <= '0;
      end else begin
         cycle_count_q  <= cycle_count_d;
         retire_count_q <= retire_count_d;
         halt_cause_q   <= halt_cause_d;
         halt_pc_q      <= halt_pc_d;
      end
   end

   // Writeback trace buffer, flushed on every start
   trace_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (TRACE_DEPTH)
   ) u_trace_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (start),
      .push     (trace_push),
      .push_dat (push_entry),
      .pop      (trace_pop),
      .head_dat (head_entry),
      .head_vld (trace_valid),
      .level    (trace_level),
      .overflow (trace_overflow)
   );

   // Output unpacking
   always_comb begin
      running      = running_q;
      halted       = halted_q;
      halt_cause   = halt_cause_q;
      cycle_count  = cycle_count_q;
      retire_count = retire_count_q;
      trace_pc     = head_entry[ENTRY_W-1 -: XLEN];
      trace_rd     = head_entry[XLEN +: REG_IDX_W];
      trace_data   = head_entry[XLEN-1:0];
   end

endmodule

// File: tb/tb_core_run_monitor.sv
module tb_core_run_monitor;

   localparam int XLEN  = 32;
   localparam int CW    = 64;
   localparam int DEPTH = 4;
   localparam int TX0   = 0;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic            clear = 1'b0;
   logic [CW-1:0]   timeout_cycles = '0;
   logic            filter_en = 1'b0;
   logic [4:0]      filter_rd = '0;
   logic            wb_wen = 1'b0;
   logic [4:0]      wb_rd = '0;
   logic [XLEN-1:0] wb_data = '0;
   logic [XLEN-1:0] wb_pc = '0;
   logic            ecall_pulse = 1'b0;
   logic            ebreak_pulse = 1'b0;
   logic [XLEN-1:0] halt_pc = '0;
   logic            trace_pop = 1'b0;

   logic            running, halted, trace_valid, trace_overflow;
   logic [1:0]      halt_cause;
   logic [XLEN-1:0] halt_pc_q, trace_pc, trace_data;
   logic [CW-1:0]   cycle_count, retire_count;
   logic [4:0]      trace_rd;
   logic [LW-1:0]   trace_level;

   core_run_monitor #(
      .XLEN(XLEN), .CYCLE_W(CW), .TRACE_DEPTH(DEPTH), .TRACE_X0(TX0)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
      .timeout_cycles(timeout_cycles), .filter_en(filter_en), .filter_rd(filter_rd),
      .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data), .wb_pc(wb_pc),
      .ecall_pulse(ecall_pulse), .ebreak_pulse(ebreak_pulse), .halt_pc(halt_pc),
      .running(running), .halted(halted), .halt_cause(halt_cause), .halt_pc_q(halt_pc_q),
      .cycle_count(cycle_count), .retire_count(retire_count),
      .trace_valid(trace_valid), .trace_pc(trace_pc), .trace_rd(trace_rd),
      .trace_data(trace_data), .trace_pop(trace_pop), .trace_level(trace_level),
      .trace_overflow(trace_overflow)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [XLEN-1:0] pc;
      logic [4:0]      rd;
      logic [XLEN-1:0] data;
   } ent_t;

   ent_t            mq[$];
   int              m_state;   // 0 idle, 1 run, 2 halted
   longint unsigned m_cyc, m_ret;
   int              m_cause;
   logic [XLEN-1:0] m_hpc;
   bit              m_ovf;

   task automatic model_reset();
      mq.delete();
      m_state = 0; m_cyc = 0; m_ret = 0; m_cause = 0; m_hpc = '0; m_ovf = 0;
   endtask

   // One clock edge of the monitor, from the current inputs
   task automatic model_step();
      longint unsigned to;
      bit push, pop_ok;
      ent_t e;
      to = timeout_cycles;
      if (start) begin
         m_state = 1; m_cyc = 0; m_ret = 0; m_cause = 0; m_ovf = 0;
         mq.delete();
         return;
      end
      pop_ok = trace_pop && (mq.size() > 0);
      push = 0;
      if (m_state == 1) begin
         push = wb_wen && (wb_rd != 0 || TX0 != 0) && (!filter_en || wb_rd == filter_rd);
         if (wb_wen && wb_rd != 0) m_ret++;
         if (ecall_pulse)                      begin m_cause = 1; m_hpc = halt_pc; m_state = 2; end
         else if (ebreak_pulse)                begin m_cause = 2; m_hpc = halt_pc; m_state = 2; end
         else if (to != 0 && m_cyc == to - 1)  begin m_cause = 3; m_hpc = halt_pc; m_state = 2; end
         m_cyc++;
      end else if (m_state == 2 && clear) begin
         m_state = 0;
      end
      if (pop_ok) void'(mq.pop_front());
      if (push) begin
         if (mq.size() < DEPTH) begin
            e.pc = wb_pc; e.rd = wb_rd; e.data = wb_data;
            mq.push_back(e);
         end else m_ovf = 1;
      end
   endtask

   task automatic compare_all();
      chk("running", running, m_state == 1);
      chk("halted", halted, m_state == 2);
      chk("halt_cause", halt_cause, m_cause);
      chk("halt_pc_q", halt_pc_q, m_hpc);
      chk("cycle_count", cycle_count, m_cyc);
      chk("retire_count", retire_count, m_ret);
      chk("trace_level", trace_level, mq.size());
      chk("trace_valid", trace_valid, mq.size() > 0);
      chk("trace_overflow", trace_overflow, m_ovf);
      if (mq.size() > 0) begin
         chk("trace_pc", trace_pc, mq[0].pc);
         chk("trace_rd", trace_rd, mq[0].rd);
         chk("trace_data", trace_data, mq[0].data);
      end
   endtask

   // Apply current inputs for one cycle, check, then drop the one-shot inputs
   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      compare_all();
      start = 0; clear = 0; ecall_pulse = 0; ebreak_pulse = 0;
      trace_pop = 0; wb_wen = 0;
   endtask

   task automatic wb(input logic [4:0] rd, input logic [XLEN-1:0] data);
      wb_wen = 1; wb_rd = rd; wb_data = data; wb_pc = 32'h1000 + {rd, 2'b00};
      tick();
   endtask

   initial begin
      model_reset();
      #2;
      compare_all();
      chk("reset_running", running, 0);
      @(negedge clk);
      rst_n = 1;

      // ecall at RUN cycle 10
      start = 1; tick();
      for (int i = 0; i < 10; i++) tick();
      ecall_pulse = 1; halt_pc = 32'h40; tick();
      chk("t1_halted", halted, 1);
      chk("t1_cause", halt_cause, 1);
      chk("t1_hpc", halt_pc_q, 32'h40);
      chk("t1_cycles", cycle_count, 11);
      ecall_pulse = 1; tick();                 // ignored outside RUN
      chk("t1_ecall_ignored_cycles", cycle_count, 11);
      clear = 1; tick();
      chk("t1_clear_idle", halted, 0);

      // timeout = 5
      timeout_cycles = 5;
      start = 1; tick();
      for (int i = 0; i < 20 && !halted; i++) tick();
      chk("t2_timeout_halted", halted, 1);
      chk("t2_cause", halt_cause, 3);
      chk("t2_cycles", cycle_count, 5);
      timeout_cycles = 0;
      start = 1; tick();
      ecall_pulse = 1; ebreak_pulse = 1; tick();
      chk("t2_ecall_priority", halt_cause, 1);

      // x0 suppression
      start = 1; tick();
      wb(5'd1, 32'hA); wb(5'd0, 32'hB); wb(5'd2, 32'hC);
      chk("t3_level", trace_level, 2);
      chk("t3_retire", retire_count, 2);
      chk("t3_head0_rd", trace_rd, 1);
      chk("t3_head0_data", trace_data, 32'hA);
      trace_pop = 1; tick();
      chk("t3_head1_rd", trace_rd, 2);
      chk("t3_head1_data", trace_data, 32'hC);
      trace_pop = 1; tick();
      chk("t3_empty", trace_valid, 0);
      trace_pop = 1; tick();                   // pop on empty ignored
      chk("t3_pop_empty_level", trace_level, 0);

      // overflow at depth 4
      for (int i = 1; i <= 5; i++) wb(5'(i), 32'(i));
      chk("t4_level_full", trace_level, 4);
      chk("t4_overflow", trace_overflow, 1);
      chk("t4_head", trace_data, 1);
      trace_pop = 1; wb(5'd6, 32'd6);
      chk("t4_pushpop_level", trace_level, 4);
      chk("t4_pushpop_head", trace_data, 2);
      begin
         logic [XLEN-1:0] exp_d [4];
         exp_d[0] = 2; exp_d[1] = 3; exp_d[2] = 4; exp_d[3] = 6;
         for (int i = 0; i < 4; i++) begin
            chk("t4_drain", trace_data, exp_d[i]);
            trace_pop = 1; tick();
         end
      end

      // rd filter
      start = 1; tick();
      filter_en = 1; filter_rd = 5;
      wb(5'd3, 32'h30); wb(5'd5, 32'h50); wb(5'd7, 32'h70); wb(5'd5, 32'h51);
      chk("t5_level", trace_level, 2);
      chk("t5_retire", retire_count, 4);
      chk("t5_head_rd", trace_rd, 5);
      chk("t5_head_data", trace_data, 32'h50);
      filter_en = 0;

      // reset mid-run
      start = 1; tick();
      wb(5'd1, 32'h11); wb(5'd2, 32'h22); wb(5'd3, 32'h33);
      #2;
      rst_n = 0;
      model_reset();
      #1;
      compare_all();
      chk("t6_rst_level", trace_level, 0);
      chk("t6_rst_data", trace_data, 0);
      @(negedge clk);
      rst_n = 1;

      // restart from HALTED with full, overflowed FIFO
      start = 1; tick();
      for (int i = 1; i <= 5; i++) wb(5'(i), 32'(i + 100));
      ebreak_pulse = 1; tick();
      chk("t6_halt_cause", halt_cause, 2);
      chk("t6_halt_ovf", trace_overflow, 1);
      chk("t6_halted_keeps", trace_level, 4);
      start = 1; tick();
      chk("t6_restart_level", trace_level, 0);
      chk("t6_restart_ovf", trace_overflow, 0);
      chk("t6_restart_cause", halt_cause, 0);
      chk("t6_restart_running", running, 1);

      // randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         start        = ($urandom % 50) == 0;
         clear        = ($urandom % 20) == 0;
         ecall_pulse  = ($urandom % 40) == 0;
         ebreak_pulse = ($urandom % 60) == 0;
         trace_pop    = $urandom % 2;
         wb_wen       = ($urandom % 3) != 0;
         wb_rd        = 5'($urandom % 8);
         wb_data      = $urandom;
         wb_pc        = $urandom;
         halt_pc      = $urandom;
         if (($urandom % 100) == 0) filter_en = ~filter_en;
         if (($urandom % 100) == 0) filter_rd = 5'($urandom % 8);
         if (start) timeout_cycles = CW'($urandom % 30);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
